sio_macro_seq_ctrl: RTL and testbench
=====================================

Name: sio_macro_seq_ctrl

Overview:
- Sequencer for one SIO macro (two SIO pads plus the shared reference generator).
- Owns power-up enable ordering, reference configuration (VOH_SEL, VREF_SEL, VREG_EN_REFGEN, VTRIP_SEL_REFGEN), pad hold (HLD_H_N) and sleep entry/exit.
- Accepts runtime reconfiguration through a valid/ready handshake. Pads are held before any reference change and released only after a settle interval.
- Sits in the core-side I/O control logic, directly driving the macro's refgen/enable/hold inputs.

Parameters:
- PWRUP_CYCLES, 64, cycles ENABLE_H/ENABLE_VDDA_H held before first reference config (>=1)
- SETTLE_CYCLES, 32, cycles reference outputs settle with pads held (>=1)
- HOLD_SETUP_CYCLES, 2, cycles HLD_H_N low before reference outputs change (>=1)
- CNT_W, 8, timer width; elaboration error if any *_CYCLES > 2**CNT_W

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous active-high reset
- EN  in  1  macro enable request; level-sensitive
- SLEEP_REQ  in  1  request pads held and refgen hold asserted
- CFG_VALID  in  1  new reference config offered
- CFG_READY  out  1  config accepted when CFG_VALID && CFG_READY at rising CLK
- CFG_VOH_SEL  in  3  requested VOH_SEL
- CFG_VREF_SEL  in  2  requested VREF_SEL
- CFG_VREG_EN  in  1  requested VREG_EN_REFGEN
- CFG_VTRIP_SEL  in  1  requested VTRIP_SEL_REFGEN
- ENABLE_H  out  1  to macro
- ENABLE_VDDA_H  out  1  to macro
- VOH_SEL  out  3  to macro refgen
- VREF_SEL  out  2  to macro refgen
- VREG_EN_REFGEN  out  1  to macro
- VTRIP_SEL_REFGEN  out  1  to macro
- HLD_H_N_REFGEN  out  1  refgen hold, active-low
- HLD_H_N  out  2  per-pad hold, active-low; both bits always equal
- READY  out  1  macro active and pads released
- STATE  out  3  current state encoding, for debug

Behaviour:
- Reset (async, active-high) gives state OFF.
  - All outputs are 0, so HLD_H_N=2'b00 and HLD_H_N_REFGEN=0 (held).
  - Shadow config is 0 (VOH_SEL=0, VREF_SEL=0, VREG_EN=0, VTRIP_SEL=0).
  - Pending config is 0 and the timer is 0.
- All outputs are registered.
- Reference outputs always equal the shadow registers.
- States: OFF=0, PWRUP=1, SETTLE=2, ACTIVE=3, HOLD=4, SLEEP=5.
- Global rule: EN=0 in any state sends the next state to OFF. This takes priority over every other transition. Shadow config is kept.
- OFF:
  - ENABLE_H=ENABLE_VDDA_H=0; holds asserted.
  - EN=1 -> PWRUP, timer loaded with PWRUP_CYCLES-1.
- PWRUP:
  - ENABLE_H=ENABLE_VDDA_H=1; holds asserted.
  - Timer decrements each cycle; at timer==0 -> SETTLE, timer loaded with SETTLE_CYCLES-1.
  - Result: ENABLE_H is high for exactly PWRUP_CYCLES cycles before SETTLE.
- SETTLE:
  - Enables stay 1; HLD_H_N=00; HLD_H_N_REFGEN=0.
  - At timer==0 -> ACTIVE.
- ACTIVE:
  - HLD_H_N=11, HLD_H_N_REFGEN=1, READY=1.
  - CFG_READY = (state==ACTIVE) && !SLEEP_REQ; it is combinational from the state register and SLEEP_REQ.
  - SLEEP_REQ=1 -> SLEEP. This takes priority over a config request; no config is accepted that cycle.
  - Otherwise, a handshake captures CFG_* into pending -> HOLD, timer loaded with HOLD_SETUP_CYCLES-1.
- HOLD:
  - HLD_H_N=00 and HLD_H_N_REFGEN=0 from the first HOLD cycle.
  - Reference outputs are unchanged.
  - At timer==0: shadow <= pending (outputs change on that edge) -> SETTLE, timer loaded with SETTLE_CYCLES-1.
  - Result: holds are low for at least HOLD_SETUP_CYCLES cycles before any reference output changes.
- SLEEP:
  - Enables stay 1; HLD_H_N=00; HLD_H_N_REFGEN=0.
  - SLEEP_REQ=0 -> SETTLE, with a full settle before release.
- READY=1 only in ACTIVE; it drops the cycle after leaving ACTIVE.
- A config offered outside ACTIVE waits: CFG_VALID is held by the producer, and CFG_* must be stable while CFG_VALID && !CFG_READY.
- EN falling mid-HOLD discards pending; shadow is not updated.
- Re-asserting EN from OFF always replays the full PWRUP and SETTLE sequence.
- STATE reflects the registered state.

Decomposition:
- Package sio_macro_seq_pkg:
  - state enum (3-bit, encodings above);
  - cfg struct {voh_sel[2:0], vref_sel[1:0], vreg_en, vtrip_sel}.
- Sub-module sio_macro_seq_timer: loadable down-counter of width CNT_W with load value and a zero flag, instantiated once.

Test Plan:
- Power-up: RESET pulse, EN=1 -> ENABLE_H high 64 cycles, then SETTLE for 32 cycles with HLD_H_N=00, then READY=1, HLD_H_N=11, VOH_SEL=0.
- Reconfig: in ACTIVE, CFG_VALID with VOH_SEL=3'b101, VREF_SEL=2'b10 -> HLD_H_N=00 next cycle; VOH_SEL changes exactly 2 cycles later; READY returns after 32 more cycles.
- Sleep vs config collision: in ACTIVE assert SLEEP_REQ and CFG_VALID together -> CFG_READY=0, state SLEEP, VOH_SEL unchanged. Drop SLEEP_REQ -> SETTLE(32) -> ACTIVE, then config accepted.
- EN drop mid-HOLD: deassert EN on the first HOLD cycle -> next state OFF, enables 0, shadow keeps the old value. Re-enable -> full 64+32 sequence.
- Async reset mid-SETTLE: RESET asserted asynchronously -> all outputs 0 immediately without a clock edge; STATE=0.

Source files
------------

// File: rtl/sio_macro_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// sio_macro_seq_pkg : state encoding and reference-config record | rev 1.0
// ============================================================================
package sio_macro_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_PWRUP  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_SLEEP  = 3'd5
  } state_e;

  typedef struct packed {
    logic [2:0] voh_sel;
    logic [1:0] vref_sel;
    logic       vreg_en;
    logic       vtrip_sel;
  } cfg_t;

endpackage
`default_nettype wire

// File: rtl/sio_macro_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// sio_macro_seq_ctrl_if : reference-config valid/ready channel | rev 1.0
// ============================================================================
import sio_macro_seq_pkg::*;

interface sio_macro_seq_ctrl_if;
  logic cfg_valid;
  logic cfg_ready;
  cfg_t cfg;

  modport master (output cfg_valid, output cfg, input cfg_ready);
  modport slave  (input cfg_valid, input cfg, output cfg_ready);
endinterface
`default_nettype wire

// File: rtl/sio_macro_seq_ctrl_timer.sv
`default_nettype none
// ============================================================================
// sio_macro_seq_timer : loadable down-counter, saturates at zero | rev 1.0
// ============================================================================
module sio_macro_seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/sio_macro_seq_ctrl.sv
`default_nettype none
// ============================================================================
// sio_macro_seq_ctrl : power-up, hold and refgen sequencer for one SIO macro | rev 1.0
// ============================================================================
import sio_macro_seq_pkg::*;

module sio_macro_seq_ctrl #(
  parameter int PWRUP_CYCLES      = 64,
  parameter int SETTLE_CYCLES     = 32,
  parameter int HOLD_SETUP_CYCLES = 2,
  parameter int CNT_W             = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_sleep_req,
  sio_macro_seq_ctrl_if.slave   cfg_if,
  output logic                  o_enable_h,
  output logic                  o_enable_vdda_h,
  output logic [2:0]            o_voh_sel,
  output logic [1:0]            o_vref_sel,
  output logic                  o_vreg_en_refgen,
  output logic                  o_vtrip_sel_refgen,
  output logic                  o_hld_h_n_refgen,
  output logic [1:0]            o_hld_h_n,
  output logic                  o_ready,
  output logic [2:0]            o_state
);

  localparam longint c_CNT_MAX = longint'(1) << CNT_W;

  if (PWRUP_CYCLES < 1 || SETTLE_CYCLES < 1 || HOLD_SETUP_CYCLES < 1 ||
      PWRUP_CYCLES > c_CNT_MAX || SETTLE_CYCLES > c_CNT_MAX ||
      HOLD_SETUP_CYCLES > c_CNT_MAX) begin : g_bad_params
    $error("sio_macro_seq_ctrl: cycle parameter out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] c_PWRUP_LD  = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_HOLD_LD   = CNT_W'(HOLD_SETUP_CYCLES - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  cfg_t             r_shadow;
  cfg_t             r_pending;
  logic             r_enable;
  logic             r_active;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_zero;
  logic             w_cfg_ready;
  logic             w_accept;
  logic             w_commit;

  sio_macro_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  assign w_cfg_ready      = (r_state == ST_ACTIVE) && !i_sleep_req;
  assign cfg_if.cfg_ready = w_cfg_ready;

  // EN low overrides every transition, including an in-flight handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    if (!i_en) begin
      w_state_nxt = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_state_nxt = ST_PWRUP;
          w_load      = 1'b1;
          w_load_val  = c_PWRUP_LD;
        end
        ST_PWRUP: begin
          if (w_zero) begin
            w_state_nxt = ST_SETTLE;
            w_load      = 1'b1;
            w_load_val  = c_SETTLE_LD;
          end
        end
        ST_SETTLE: begin
          if (w_zero) begin
            w_state_nxt = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (i_sleep_req) begin
            w_state_nxt = ST_SLEEP;
          end else if (cfg_if.cfg_valid) begin
            w_state_nxt = ST_HOLD;
            w_accept    = 1'b1;
            w_load      = 1'b1;
            w_load_val  = c_HOLD_LD;
          end
        end
        ST_HOLD: begin
          if (w_zero) begin
            w_state_nxt = ST_SETTLE;
            w_commit    = 1'b1;
            w_load      = 1'b1;
            w_load_val  = c_SETTLE_LD;
          end
        end
        ST_SLEEP: begin
          if (!i_sleep_req) begin
            w_state_nxt = ST_SETTLE;
            w_load      = 1'b1;
            w_load_val  = c_SETTLE_LD;
          end
        end
        default: w_state_nxt = ST_OFF;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with STATE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_OFF;
      r_shadow  <= '0;
      r_pending <= '0;
      r_enable  <= 1'b0;
      r_active  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_enable <= (w_state_nxt != ST_OFF);
      r_active <= (w_state_nxt == ST_ACTIVE);
      if (w_state_nxt == ST_OFF) begin
        r_pending <= '0;
      end else if (w_accept) begin
        r_pending <= cfg_if.cfg;
      end
      if (w_commit) begin
        r_shadow <= r_pending;
      end
    end
  end

  assign o_enable_h         = r_enable;
  assign o_enable_vdda_h    = r_enable;
  assign o_voh_sel          = r_shadow.voh_sel;
  assign o_vref_sel         = r_shadow.vref_sel;
  assign o_vreg_en_refgen   = r_shadow.vreg_en;
  assign o_vtrip_sel_refgen = r_shadow.vtrip_sel;
  assign o_hld_h_n_refgen   = r_active;
  assign o_hld_h_n          = {2{r_active}};
  assign o_ready            = r_active;
  assign o_state            = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sio_macro_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_sio_macro_seq_ctrl : directed bench for the SIO macro sequencer | rev 1.0
// ============================================================================
module tb_sio_macro_seq_ctrl;
  import sio_macro_seq_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  logic       sleep_req;
  logic       enable_h;
  logic       enable_vdda_h;
  logic [2:0] voh_sel;
  logic [1:0] vref_sel;
  logic       vreg_en;
  logic       vtrip_sel;
  logic       hld_refgen;
  logic [1:0] hld;
  logic       ready;
  logic [2:0] state;
  int         n_pass;
  int         n_total;

  sio_macro_seq_ctrl_if cfg_if ();

  sio_macro_seq_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .i_en               (en),
    .i_sleep_req        (sleep_req),
    .cfg_if             (cfg_if),
    .o_enable_h         (enable_h),
    .o_enable_vdda_h    (enable_vdda_h),
    .o_voh_sel          (voh_sel),
    .o_vref_sel         (vref_sel),
    .o_vreg_en_refgen   (vreg_en),
    .o_vtrip_sel_refgen (vtrip_sel),
    .o_hld_h_n_refgen   (hld_refgen),
    .o_hld_h_n          (hld),
    .o_ready            (ready),
    .o_state            (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic offer(input logic [2:0] v, input logic [1:0] r, input logic g, input logic t);
    cfg_if.cfg_valid     = 1'b1;
    cfg_if.cfg.voh_sel   = v;
    cfg_if.cfg.vref_sel  = r;
    cfg_if.cfg.vreg_en   = g;
    cfg_if.cfg.vtrip_sel = t;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    en = 1'b0;
    sleep_req = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg = '0;
    cyc(3);
    rst = 1'b0;

    chk("rst_state", 32'(state), 0);
    chk("rst_outs", {enable_h, enable_vdda_h, hld, hld_refgen, ready, voh_sel, vref_sel, vreg_en, vtrip_sel}, 0);
    chk("rst_cfg_ready", 32'(cfg_if.cfg_ready), 0);

    // Power-up: 64 cycles PWRUP, 32 cycles SETTLE, then ACTIVE.
    en = 1'b1;
    cyc(1);
    chk("pwrup_state", 32'(state), 1);
    chk("pwrup_en", {enable_h, enable_vdda_h, hld, hld_refgen}, 32'b11_00_0);
    cyc(63);
    chk("pwrup_last", 32'(state), 1);
    cyc(1);
    chk("settle_entry", {state, enable_h, hld, ready}, {3'd2, 1'b1, 2'b00, 1'b0});
    cyc(31);
    chk("settle_last", 32'(state), 2);
    cyc(1);
    chk("active_entry", {state, ready, hld, hld_refgen, voh_sel}, {3'd3, 1'b1, 2'b11, 1'b1, 3'd0});
    chk("active_cfg_ready", 32'(cfg_if.cfg_ready), 1);

    // Reconfiguration: holds drop first, refs change two cycles later.
    offer(3'b101, 2'b10, 1'b1, 1'b0);
    cyc(1);
    cfg_if.cfg_valid = 1'b0;
    chk("hold_entry", {state, hld, hld_refgen, ready, voh_sel}, {3'd4, 2'b00, 1'b0, 1'b0, 3'd0});
    cyc(1);
    chk("hold_refs_unchanged", {voh_sel, vref_sel}, {3'd0, 2'd0});
    cyc(1);
    chk("commit", {state, voh_sel, vref_sel, vreg_en, vtrip_sel, hld}, {3'd2, 3'b101, 2'b10, 1'b1, 1'b0, 2'b00});
    cyc(31);
    chk("reconf_settle_last", 32'(ready), 0);
    cyc(1);
    chk("reconf_active", {state, ready, hld}, {3'd3, 1'b1, 2'b11});

    // Sleep request wins over a simultaneous config offer.
    sleep_req = 1'b1;
    offer(3'b011, 2'b01, 1'b0, 1'b1);
    #1;
    chk("collide_cfg_ready", 32'(cfg_if.cfg_ready), 0);
    cyc(1);
    chk("sleep_entry", {state, voh_sel, hld, hld_refgen, enable_h, ready}, {3'd5, 3'b101, 2'b00, 1'b0, 1'b1, 1'b0});
    cyc(2);
    chk("sleep_stays", 32'(state), 5);
    sleep_req = 1'b0;
    cyc(1);
    chk("wake_settle", 32'(state), 2);
    cyc(31);
    chk("wake_settle_last", 32'(state), 2);
    cyc(1);
    chk("wake_active", {state, cfg_if.cfg_ready}, {3'd3, 1'b1});
    cyc(1);
    cfg_if.cfg_valid = 1'b0;
    chk("late_cfg_hold", 32'(state), 4);
    cyc(2);
    chk("late_cfg_commit", {voh_sel, vref_sel, vreg_en, vtrip_sel}, {3'b011, 2'b01, 1'b0, 1'b1});
    cyc(32);
    chk("late_cfg_active", 32'(state), 3);

    // EN drop on the first HOLD cycle discards the pending config.
    offer(3'b110, 2'b11, 1'b1, 1'b0);
    cyc(1);
    cfg_if.cfg_valid = 1'b0;
    chk("endrop_hold", 32'(state), 4);
    en = 1'b0;
    cyc(1);
    chk("endrop_off", {state, enable_h, enable_vdda_h, hld, ready}, {3'd0, 1'b0, 1'b0, 2'b00, 1'b0});
    chk("endrop_shadow", {voh_sel, vref_sel, vreg_en, vtrip_sel}, {3'b011, 2'b01, 1'b0, 1'b1});
    cyc(2);
    en = 1'b1;
    cyc(64);
    chk("reen_pwrup_last", {state, enable_h}, {3'd1, 1'b1});
    cyc(32);
    chk("reen_settle_last", 32'(state), 2);
    cyc(1);
    chk("reen_active", {state, ready, voh_sel}, {3'd3, 1'b1, 3'b011});

    // Asynchronous reset in the middle of SETTLE.
    sleep_req = 1'b1;
    cyc(1);
    sleep_req = 1'b0;
    cyc(6);
    chk("pre_reset_settle", 32'(state), 2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(state), 0);
    chk("async_rst_outs", {enable_h, enable_vdda_h, hld, hld_refgen, ready, voh_sel, vref_sel, vreg_en, vtrip_sel}, 0);
    cyc(1);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
